// File: rtl/memc_dma_pkg.sv
// Shared defaults and types for the memory-controller DMA responder.
package memc_dma_pkg;

    localparam int unsigned MEMC_ADDR_W = 24;
    localparam int unsigned MEMC_DATA_W = 32;

    typedef enum logic {
        PRI_WR = 1'b0,
        PRI_RD = 1'b1
    } memc_arb_e;

    // Data returned for reads that fall outside the SRAM.
    localparam logic [MEMC_DATA_W-1:0] MEMC_OOR_RDATA = '0;

endpackage

// File: rtl/memc_rd_fifo.sv
// Read-data return FIFO; head is always visible on o_data.
module memc_rd_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage is cleared too so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full && !w_pop));

endmodule

// File: rtl/memc_dma_resp.sv
// Lane-side DMA responder: arbitrates DMA writes/reads onto a single-port SRAM
// and returns read data in order through a credit-limited FIFO.
module memc_dma_resp
    import memc_dma_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEMC_ADDR_W,
    parameter int unsigned DATA_W    = MEMC_DATA_W,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned RDQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_poweron_n,
    input  logic              dma__memc__write_valid,
    input  logic [ADDR_W-1:0] dma__memc__write_address,
    input  logic [DATA_W-1:0] dma__memc__write_data,
    output logic              memc__dma__write_ready,
    input  logic              dma__memc__read_valid,
    input  logic [ADDR_W-1:0] dma__memc__read_address,
    output logic              memc__dma__read_ready,
    input  logic              dma__memc__read_pause,
    output logic [DATA_W-1:0] memc__dma__read_data,
    output logic              memc__dma__read_data_valid,
    output logic              memc__err_addr_range
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = $clog2(RDQ_DEPTH) + 1;

    memc_arb_e         r_arb;
    logic              r_inflight;
    logic              r_rd_oor;
    logic [AW-1:0]     r_rd_idx;
    logic              r_err;
    logic [DATA_W-1:0] r_sram [MEM_DEPTH];

    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CW:0]       w_used;
    logic              w_rd_ok;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_pop;
    logic [DATA_W-1:0] w_sram_rdata;

    assign w_wr_oor = (dma__memc__write_address >= ADDR_W'(MEM_DEPTH));
    assign w_rd_oor = (dma__memc__read_address  >= ADDR_W'(MEM_DEPTH));

    // Credit counts the in-flight SRAM read so the FIFO can never overflow.
    assign w_used  = {1'b0, w_fifo_count} + (CW+1)'(r_inflight);
    assign w_rd_ok = dma__memc__read_valid & (w_used < (CW+1)'(RDQ_DEPTH));

    assign w_wr_gnt = reset_poweron_n & dma__memc__write_valid
                    & (~w_rd_ok | (r_arb == PRI_WR));
    assign w_rd_gnt = reset_poweron_n & w_rd_ok
                    & (~dma__memc__write_valid | (r_arb == PRI_RD));

    assign memc__dma__write_ready = w_wr_gnt;
    assign memc__dma__read_ready  = w_rd_gnt;
    assign memc__err_addr_range   = r_err;

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            r_arb      <= PRI_WR;
            r_inflight <= 1'b0;
            r_rd_oor   <= 1'b0;
            r_rd_idx   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (dma__memc__write_valid && w_rd_ok) begin
                r_arb <= (r_arb == PRI_WR) ? PRI_RD : PRI_WR;
            end
            r_inflight <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_oor <= w_rd_oor;
                r_rd_idx <= dma__memc__read_address[AW-1:0];
            end
            if ((w_wr_gnt && w_wr_oor) || (w_rd_gnt && w_rd_oor)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_gnt && !w_wr_oor) begin
            r_sram[dma__memc__write_address[AW-1:0]] <= dma__memc__write_data;
        end
    end

    // Registered read address: the array is read in the cycle after accept,
    // so a write accepted one cycle earlier is already visible.
    assign w_sram_rdata = r_rd_oor ? DATA_W'(MEMC_OOR_RDATA) : r_sram[r_rd_idx];

    assign w_pop                      = ~w_fifo_empty & ~dma__memc__read_pause;
    assign memc__dma__read_data_valid = w_pop;

    memc_rd_fifo #(
        .DEPTH  (RDQ_DEPTH),
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk     (clk),
        .rst_n   (reset_poweron_n),
        .i_push  (r_inflight),
        .i_data  (w_sram_rdata),
        .i_pop   (w_pop),
        .o_data  (memc__dma__read_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    a_fifo_not_full_on_push: assert property (@(posedge clk) disable iff (!reset_poweron_n)
        !(r_inflight && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_memc_dma_resp.sv
// Scoreboard bench for memc_dma_resp: directed stimulus, queued expectations.
module tb_memc_dma_resp;

    logic        clk = 1'b0;
    logic        reset_poweron_n;
    logic        dma__memc__write_valid;
    logic [23:0] dma__memc__write_address;
    logic [31:0] dma__memc__write_data;
    logic        memc__dma__write_ready;
    logic        dma__memc__read_valid;
    logic [23:0] dma__memc__read_address;
    logic        memc__dma__read_ready;
    logic        dma__memc__read_pause;
    logic [31:0] memc__dma__read_data;
    logic        memc__dma__read_data_valid;
    logic        memc__err_addr_range;

    always #5 clk = ~clk;

    memc_dma_resp #(
        .ADDR_W    (24),
        .DATA_W    (32),
        .MEM_DEPTH (4096),
        .RDQ_DEPTH (4)
    ) dut (
        .clk                        (clk),
        .reset_poweron_n            (reset_poweron_n),
        .dma__memc__write_valid     (dma__memc__write_valid),
        .dma__memc__write_address   (dma__memc__write_address),
        .dma__memc__write_data      (dma__memc__write_data),
        .memc__dma__write_ready     (memc__dma__write_ready),
        .dma__memc__read_valid      (dma__memc__read_valid),
        .dma__memc__read_address    (dma__memc__read_address),
        .memc__dma__read_ready      (memc__dma__read_ready),
        .dma__memc__read_pause      (dma__memc__read_pause),
        .memc__dma__read_data       (memc__dma__read_data),
        .memc__dma__read_data_valid (memc__dma__read_data_valid),
        .memc__err_addr_range       (memc__err_addr_range)
    );

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   last_lat = -1;
    logic wg, rg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every transferred beat must match the oldest outstanding read.
    always @(negedge clk) begin
        if (reset_poweron_n && memc__dma__read_data_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%08h expected no beat", memc__dma__read_data);
            end else begin
                mon_e    = sb_q.pop_front();
                last_lat = cyc - mon_e.acc_cyc;
                chk("read_data", memc__dma__read_data, mon_e.data);
            end
        end
    end

    task automatic cyc_step(input logic a_wv, input logic [23:0] a_wa, input logic [31:0] a_wd,
                            input logic a_rv, input logic [23:0] a_ra, input logic [31:0] a_rexp,
                            output logic o_wg, output logic o_rg);
        exp_t e;
        dma__memc__write_valid   = a_wv;
        dma__memc__write_address = a_wa;
        dma__memc__write_data    = a_wd;
        dma__memc__read_valid    = a_rv;
        dma__memc__read_address  = a_ra;
        @(negedge clk);
        o_wg = memc__dma__write_ready;
        o_rg = memc__dma__read_ready;
        if (o_rg) begin
            e.data    = a_rexp;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        dma__memc__write_valid = 1'b0;
        dma__memc__read_valid  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_ready"}, 32'(memc__dma__write_ready), 32'd0);
        chk({tag, "_rd_ready"}, 32'(memc__dma__read_ready), 32'd0);
        chk({tag, "_rd_valid"}, 32'(memc__dma__read_data_valid), 32'd0);
        chk({tag, "_rd_data"},  memc__dma__read_data, 32'd0);
        chk({tag, "_err"},      32'(memc__err_addr_range), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    logic [23:0] t4_a [6];
    logic [31:0] t4_d [6];
    int k, j, acc;

    initial begin
        t4_a = '{24'h103, 24'h102, 24'h101, 24'h100, 24'h010, 24'h000};
        t4_d = '{32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000, 32'hA5A50001, 32'h12345678};

        // 1: reset with valids high, then first conflict goes to write
        reset_poweron_n          = 1'b0;
        dma__memc__read_pause    = 1'b0;
        dma__memc__write_valid   = 1'b1;
        dma__memc__write_address = 24'h000;
        dma__memc__write_data    = 32'h12345678;
        dma__memc__read_valid    = 1'b1;
        dma__memc__read_address  = 24'h000;
        repeat (5) begin
            @(negedge clk);
            chk_outputs_zero("rst");
        end
        @(posedge clk);
        #1;
        reset_poweron_n = 1'b1;
        @(negedge clk);
        chk("t1_conflict_wr", 32'(memc__dma__write_ready), 32'd1);
        chk("t1_conflict_rd", 32'(memc__dma__read_ready), 32'd0);
        @(posedge clk);
        #1;
        dma__memc__write_valid = 1'b0;
        dma__memc__read_valid  = 1'b0;

        // 2: write then read-after-write, latency 2
        cyc_step(1'b1, 24'h010, 32'hA5A50001, 1'b0, 24'h0, 32'h0, wg, rg);
        chk("t2_wr_accept", 32'(wg), 32'd1);
        cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'h010, 32'hA5A50001, wg, rg);
        chk("t2_rd_accept", 32'(rg), 32'd1);
        drain("t2_drain");
        chk("t2_latency", 32'(last_lat), 32'd2);

        // arbiter is now PRI_RD: a conflict must go to the read and flip back
        cyc_step(1'b1, 24'h030, 32'h0, 1'b1, 24'h010, 32'hA5A50001, wg, rg);
        chk("arb_pri_rd_wr", 32'(wg), 32'd0);
        chk("arb_pri_rd_rd", 32'(rg), 32'd1);
        drain("arb_drain");

        // 3: both valid held for 8 cycles
        k = 0;
        j = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_step(1'b1, 24'(24'h100 + k), 32'(32'hC0DE0000 + k),
                     1'b1, 24'(24'h100 + j), 32'(32'hC0DE0000 + j), wg, rg);
            chk("t3_wr_grant", 32'(wg), 32'((i % 2) == 0));
            chk("t3_rd_grant", 32'(rg), 32'((i % 2) == 1));
            if (wg) k++;
            if (rg) j++;
        end
        chk("t3_writes", 32'(k), 32'd4);
        chk("t3_reads", 32'(j), 32'd4);
        drain("t3_drain");

        // 4: paused, credit limits acceptance to 4
        dma__memc__read_pause = 1'b1;
        acc = 0;
        for (int t = 0; t < 8; t++) begin
            automatic logic e_rg = (acc < 4);
            cyc_step(1'b0, 24'h0, 32'h0, 1'b1, t4_a[acc], t4_d[acc], wg, rg);
            chk("t4_rd_ready_paused", 32'(rg), 32'(e_rg));
            if (rg) acc++;
        end
        @(negedge clk);
        chk("t4_paused_no_valid", 32'(memc__dma__read_data_valid), 32'd0);
        chk("t4_head_stable", memc__dma__read_data, 32'hC0DE0003);
        chk("t4_accepted_paused", 32'(acc), 32'd4);
        @(posedge clk);
        #1;
        dma__memc__read_pause = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_t e;
            dma__memc__read_valid   = (acc < 6);
            dma__memc__read_address = t4_a[acc < 6 ? acc : 0];
            @(negedge clk);
            chk("t4_beat_consec", 32'(memc__dma__read_data_valid), 32'd1);
            if (memc__dma__read_ready) begin
                e.data    = t4_d[acc];
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        dma__memc__read_valid = 1'b0;
        for (int t = 0; t < 10 && acc < 6; t++) begin
            cyc_step(1'b0, 24'h0, 32'h0, 1'b1, t4_a[acc], t4_d[acc], wg, rg);
            if (rg) acc++;
        end
        chk("t4_accepted_total", 32'(acc), 32'd6);
        drain("t4_drain");

        // 5: out-of-range accesses
        chk("t5_err_clear", 32'(memc__err_addr_range), 32'd0);
        cyc_step(1'b1, 24'd4096, 32'hDEADBEEF, 1'b0, 24'h0, 32'h0, wg, rg);
        chk("t5_oor_wr_accept", 32'(wg), 32'd1);
        chk("t5_err_set", 32'(memc__err_addr_range), 32'd1);
        cyc_step(1'b1, 24'h801000, 32'h55555555, 1'b0, 24'h0, 32'h0, wg, rg);
        cyc_step(1'b1, 24'd4095, 32'h0BADF00D, 1'b0, 24'h0, 32'h0, wg, rg);
        cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'd4096, 32'h0, wg, rg);
        chk("t5_oor_rd_accept", 32'(rg), 32'd1);
        cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'h000, 32'h12345678, wg, rg);
        cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'd4095, 32'h0BADF00D, wg, rg);
        drain("t5_drain");
        repeat (5) @(posedge clk);
        #1;
        chk("t5_err_sticky", 32'(memc__err_addr_range), 32'd1);

        // 6: reset with 3 entries held in the FIFO
        dma__memc__read_pause = 1'b1;
        repeat (3) cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'h010, 32'hA5A50001, wg, rg);
        repeat (3) @(posedge clk);
        #1;
        reset_poweron_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk_outputs_zero("t6_rst");
        @(posedge clk);
        #1;
        reset_poweron_n       = 1'b1;
        dma__memc__read_pause = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_stale", 32'(memc__dma__read_data_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        dma__memc__read_pause = 1'b1;
        for (int t = 0; t < 5; t++) begin
            cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'h100, 32'hC0DE0000, wg, rg);
            chk("t6_credit_full", 32'(rg), 32'(t < 4));
        end
        dma__memc__read_pause = 1'b0;
        drain("t6_drain_credit");
        cyc_step(1'b0, 24'h0, 32'h0, 1'b1, 24'h010, 32'hA5A50001, wg, rg);
        chk("t6_rd_accept", 32'(rg), 32'd1);
        drain("t6_drain");
        chk("t6_latency", 32'(last_lat), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
